// File: rtl/dispatch_engine.sv
// -----------------------------------------------------------------------------
// dispatch_engine
//
// Command dispatcher sitting between the host command FIFO and the protocol
// facade. Each command word is {opcode[7:0], payload[DATA_W-1:0]}.
//   * Opcodes 0x00..0x03 are forwarded to the facade (go/done handshake), and
//     the received byte is returned to the response FIFO.
//   * Opcodes 0x10..0x13 drive/read an AUX_N-channel pin bank.
//   * Opcodes 0x20/0x21 implement a cycle delay with a loadable high byte.
//   * Anything else, including an AUX channel index >= AUX_N, sets a sticky
//     error flag.
//
// Ports:
//   clock, reset           system clock, asynchronous active-high reset
//   in_nempty/in_data      first-word-fall-through command FIFO head
//   in_pop                 one-cycle pop strobe (only ever high in IDLE)
//   out_full/out_push      response FIFO full flag / one-cycle push strobe
//   out_data               {opcode echo, result}
//   fac_go/fac_cmd         facade start strobe and command (0 data, 1 start,
//                          2 stop, 3 reserved-bitwise)
//   fac_data               byte to facade, held from go until done
//   fac_done/fac_rx        facade completion strobe and received byte
//   aux_out/aux_oe/aux_in  AUX drive level, output enable (0 = Hi-Z), readback
//   busy                   high whenever the FSM is not in IDLE
//   error/error_clr        sticky unknown-opcode flag and its clear
// -----------------------------------------------------------------------------
module dispatch_engine #(
  parameter int DATA_W  = 8,
  parameter int AUX_N   = 4,
  parameter int DELAY_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_nempty,
  input  logic [8+DATA_W-1:0]   in_data,
  output logic                  in_pop,
  input  logic                  out_full,
  output logic                  out_push,
  output logic [8+DATA_W-1:0]   out_data,
  output logic                  fac_go,
  output logic [1:0]            fac_cmd,
  output logic [DATA_W-1:0]     fac_data,
  input  logic                  fac_done,
  input  logic [DATA_W-1:0]     fac_rx,
  output logic [AUX_N-1:0]      aux_out,
  output logic [AUX_N-1:0]      aux_oe,
  input  logic [AUX_N-1:0]      aux_in,
  output logic                  busy,
  output logic                  error,
  input  logic                  error_clr
);

  localparam int CH_W = (AUX_N > 1) ? $clog2(AUX_N) : 1;
  // Channel limit widened by one bit so AUX_N = 256 is representable.
  localparam logic [DATA_W:0] AUX_N_L = (DATA_W + 1)'(AUX_N);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FAC_WAIT,
    ST_DELAY,
    ST_PUSH
  } state_t;

  state_t                 state_reg;
  logic [8+DATA_W-1:0]    cmd_reg;
  logic [DATA_W-1:0]      delay_hi_reg;
  logic [DELAY_W-1:0]     count_reg;
  logic [8+DATA_W-1:0]    out_data_reg;
  logic                   fac_go_reg;
  logic [1:0]             fac_cmd_reg;
  logic [DATA_W-1:0]      fac_data_reg;
  logic [AUX_N-1:0]       aux_out_reg;
  logic [AUX_N-1:0]       aux_oe_reg;
  logic                   error_reg;

  logic [7:0]             opcode;
  logic [DATA_W-1:0]      payload;
  logic [CH_W-1:0]        ch;
  logic                   ch_ok;
  logic [AUX_N-1:0]       ch_sel;
  logic                   aux_rd;
  logic [2*DATA_W-1:0]    delay_cat;

  assign opcode    = cmd_reg[8+DATA_W-1 -: 8];
  assign payload   = cmd_reg[DATA_W-1:0];
  assign ch        = payload[CH_W-1:0];
  // The whole payload is range-checked, not just the index bits, so e.g.
  // channel 9 on a 4-channel bank is rejected rather than aliased to 1.
  assign ch_ok     = ({1'b0, payload} < AUX_N_L);
  assign delay_cat = {delay_hi_reg, payload};

  // One-hot channel select; all-zero when the index is out of range, which
  // makes the AUX update expressions below harmless on a bad channel.
  genvar gi;
  generate
    for (gi = 0; gi < AUX_N; gi++) begin : g_ch_sel
      assign ch_sel[gi] = ch_ok && (ch == CH_W'(gi));
    end
  endgenerate

  assign aux_rd = |(aux_in & ch_sel);

  // Pop is combinational so the FIFO head is consumed in the same cycle it is
  // latched; gating with reset keeps the FIFO untouched while held in reset.
  assign in_pop   = (state_reg == ST_IDLE) && in_nempty && !reset;
  assign out_push = (state_reg == ST_PUSH) && !out_full;
  assign busy     = (state_reg != ST_IDLE);

  assign out_data = out_data_reg;
  assign fac_go   = fac_go_reg;
  assign fac_cmd  = fac_cmd_reg;
  assign fac_data = fac_data_reg;
  assign aux_out  = aux_out_reg;
  assign aux_oe   = aux_oe_reg;
  assign error    = error_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      delay_hi_reg <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
      fac_go_reg   <= 1'b0;
      fac_cmd_reg  <= 2'd0;
      fac_data_reg <= '0;
      aux_out_reg  <= '0;
      aux_oe_reg   <= '0;
      error_reg    <= 1'b0;
    end else begin
      fac_go_reg <= 1'b0;
      // Clear first; a new error raised below in the same cycle overrides it.
      if (error_clr) begin
        error_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (in_nempty) begin
            cmd_reg   <= in_data;
            state_reg <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          state_reg <= ST_IDLE;
          case (opcode)
            8'h00, 8'h01, 8'h02, 8'h03: begin
              fac_cmd_reg  <= opcode[1:0];
              fac_data_reg <= payload;
              fac_go_reg   <= 1'b1;
              state_reg    <= ST_FAC_WAIT;
            end
            8'h10: begin
              if (ch_ok) begin
                aux_out_reg <= aux_out_reg & ~ch_sel;
                aux_oe_reg  <= aux_oe_reg | ch_sel;
              end else begin
                error_reg <= 1'b1;
              end
            end
            8'h11: begin
              if (ch_ok) begin
                aux_out_reg <= aux_out_reg | ch_sel;
                aux_oe_reg  <= aux_oe_reg | ch_sel;
              end else begin
                error_reg <= 1'b1;
              end
            end
            8'h12: begin
              if (ch_ok) begin
                aux_oe_reg <= aux_oe_reg & ~ch_sel;
              end else begin
                error_reg <= 1'b1;
              end
            end
            8'h13: begin
              if (ch_ok) begin
                out_data_reg <= {opcode, DATA_W'(aux_rd)};
                state_reg    <= ST_PUSH;
              end else begin
                error_reg <= 1'b1;
              end
            end
            8'h20: begin
              count_reg    <= DELAY_W'(delay_cat);
              delay_hi_reg <= '0;
              state_reg    <= ST_DELAY;
            end
            8'h21: begin
              delay_hi_reg <= payload;
            end
            default: begin
              error_reg <= 1'b1;
            end
          endcase
        end

        ST_FAC_WAIT: begin
          if (fac_done) begin
            out_data_reg <= {opcode, fac_rx};
            state_reg    <= ST_PUSH;
          end
        end

        // A loaded value V spends V+1 cycles here: the cycle that sees zero
        // still counts.
        ST_DELAY: begin
          if (count_reg == '0) begin
            state_reg <= ST_IDLE;
          end else begin
            count_reg <= count_reg - DELAY_W'(1);
          end
        end

        ST_PUSH: begin
          if (!out_full) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
